// File: rtl/uart_apb_tx_sequencer.sv
// APB master draining a byte FIFO into the UART APB slave, one write per byte,
// using PREADY (TXIF) as completion and owning the slave's uart_control word.
module uart_apb_tx_sequencer #(
   parameter int          DEPTH     = 8,
   parameter logic [31:0] UART_ADDR = 32'h0000_0000,
   parameter logic [7:0]  CTRL_INIT = 8'h27,
   parameter int          TIMEOUT   = 1024
) (
   input  logic                       PCLK,
   input  logic                       PRESETn,
   input  logic                       wr_valid,
   input  logic [7:0]                 wr_data,
   output logic                       wr_ready,
   input  logic                       enable,
   input  logic                       ctrl_we,
   input  logic [7:0]                 ctrl_wdata,
   output logic [7:0]                 uart_control,
   output logic [31:0]                M_PADDR,
   output logic                       M_PSEL,
   output logic                       M_PENABLE,
   output logic                       M_PWRITE,
   output logic [31:0]                M_PWDATA,
   input  logic                       M_PREADY,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic                       busy,
   output logic                       tx_done,
   output logic                       timeout_err,
   input  logic                       clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t          state;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [TW-1:0]   tcnt;
   logic            ctrl_pend;
   logic [7:0]      ctrl_pend_val;
   logic            push, pop, abort;

   assign wr_ready = (fifo_count != CW'(DEPTH));
   assign busy     = (state != IDLE);
   assign push     = wr_valid & wr_ready;
   assign pop      = (state == IDLE) & enable & (fifo_count != '0);
   assign abort    = (state == ACCESS) & ~M_PREADY & (tcnt == T_LAST);

   // FIFO storage carries data only; validity is tracked by the pointers/count
   always_ff @(posedge PCLK) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state     <= IDLE;
         M_PSEL    <= 1'b0;
         M_PENABLE <= 1'b0;
         M_PWRITE  <= 1'b0;
         M_PADDR   <= '0;
         M_PWDATA  <= '0;
         tcnt      <= '0;
         tx_done   <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  state    <= SETUP;
                  M_PSEL   <= 1'b1;
                  M_PWRITE <= 1'b1;
                  M_PADDR  <= UART_ADDR;
                  M_PWDATA <= {24'h0, mem[rd_ptr]};
                  tcnt     <= '0;
               end
            end
            SETUP: begin
               state     <= ACCESS;
               M_PENABLE <= 1'b1;
            end
            ACCESS: begin
               // completion and abort both end the transfer; only completion reports tx_done
               if (M_PREADY || abort) begin
                  state     <= IDLE;
                  M_PSEL    <= 1'b0;
                  M_PENABLE <= 1'b0;
                  M_PWRITE  <= 1'b0;
                  tx_done   <= M_PREADY;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         timeout_err <= 1'b0;
      end else if (abort) begin
         timeout_err <= 1'b1;
      end else if (clr_err) begin
         timeout_err <= 1'b0;
      end
   end

   // config writes during a transfer are parked and applied once the FSM is idle
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         uart_control  <= CTRL_INIT;
         ctrl_pend     <= 1'b0;
         ctrl_pend_val <= '0;
      end else if (state == IDLE) begin
         ctrl_pend <= 1'b0;
         if (ctrl_we)        uart_control <= ctrl_wdata;
         else if (ctrl_pend) uart_control <= ctrl_pend_val;
      end else if (ctrl_we) begin
         ctrl_pend     <= 1'b1;
         ctrl_pend_val <= ctrl_wdata;
      end
   end

endmodule

// File: tb/tb_uart_apb_tx_sequencer.sv
// Bench for uart_apb_tx_sequencer: table of single-byte transfers plus hand-written
// fill/stall, timeout, deferred-config, enable and reset sequences; PWDATA scoreboarded.
module tb_uart_apb_tx_sequencer;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 1024;

   logic        PCLK = 1'b0;
   logic        PRESETn = 1'b0;
   logic        wr_valid = 1'b0;
   logic [7:0]  wr_data = '0;
   logic        wr_ready;
   logic        enable = 1'b1;
   logic        ctrl_we = 1'b0;
   logic [7:0]  ctrl_wdata = '0;
   logic [7:0]  uart_control;
   logic [31:0] M_PADDR;
   logic        M_PSEL, M_PENABLE, M_PWRITE;
   logic [31:0] M_PWDATA;
   logic        M_PREADY = 1'b1;
   logic [3:0]  fifo_count;
   logic        busy, tx_done, timeout_err;
   logic        clr_err = 1'b0;

   uart_apb_tx_sequencer #(.DEPTH(DEPTH), .UART_ADDR(32'h0000_0000), .CTRL_INIT(8'h27),
                           .TIMEOUT(TIMEOUT)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_ready(wr_ready), .enable(enable), .ctrl_we(ctrl_we), .ctrl_wdata(ctrl_wdata),
      .uart_control(uart_control), .M_PADDR(M_PADDR), .M_PSEL(M_PSEL),
      .M_PENABLE(M_PENABLE), .M_PWRITE(M_PWRITE), .M_PWDATA(M_PWDATA),
      .M_PREADY(M_PREADY), .fifo_count(fifo_count), .busy(busy), .tx_done(tx_done),
      .timeout_err(timeout_err), .clr_err(clr_err)
   );

   always #5 PCLK = ~PCLK;

   int passed = 0;
   int total  = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [7:0]  data;
      int          stall;
      logic [31:0] exp_pwdata;
   } vec_t;
   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b, input bit accept, input logic [31:0] exp32);
      check($sformatf("wr_ready_%h", b), wr_ready, accept);
      wr_valid = 1'b1;
      wr_data  = b;
      if (accept) exp_q.push_back(exp32);
      step();
      wr_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         step();
         if (tx_done) ok = 1'b1;
      end
   endtask

   // each transfer is scoreboarded in its SETUP phase, so aborted bytes are covered too
   always @(negedge PCLK) begin
      if (PRESETn && M_PSEL && !M_PENABLE) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_transfer", M_PWDATA, 32'hFFFF_FFFF);
         end else begin
            check("sb_pwdata", M_PWDATA, exp_q.pop_front());
            check("sb_pwrite", M_PWRITE, 1);
            check("sb_paddr", M_PADDR, 32'h0);
         end
      end
   end

   initial begin
      bit ok;
      int n;

      vecs[0] = '{8'h00, 0,  32'h0000_0000};
      vecs[1] = '{8'hFF, 2,  32'h0000_00FF};
      vecs[2] = '{8'h5A, 5,  32'h0000_005A};
      vecs[3] = '{8'h80, 40, 32'h0000_0080};

      // 1: reset and idle
      repeat (3) step();
      check("rst_psel", M_PSEL, 0);
      check("rst_penable", M_PENABLE, 0);
      check("rst_pwrite", M_PWRITE, 0);
      check("rst_paddr", M_PADDR, 0);
      check("rst_pwdata", M_PWDATA, 0);
      check("rst_count", fifo_count, 0);
      check("rst_wr_ready", wr_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_tx_done", tx_done, 0);
      check("rst_timeout_err", timeout_err, 0);
      check("rst_uart_control", uart_control, 8'h27);
      PRESETn = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (M_PSEL) n++;
      end
      check("idle_no_psel", n, 0);

      // 2: single byte latency
      M_PREADY = 1'b1;
      push_byte(8'hA5, 1, 32'h0000_00A5);
      check("t2_count_e0", fifo_count, 1);
      check("t2_psel_e0", M_PSEL, 0);
      step();
      check("t2_psel_e1", M_PSEL, 1);
      check("t2_penable_e1", M_PENABLE, 0);
      check("t2_pwdata_e1", M_PWDATA, 32'h0000_00A5);
      check("t2_count_e1", fifo_count, 0);
      step();
      check("t2_penable_e2", M_PENABLE, 1);
      check("t2_tx_done_e2", tx_done, 0);
      step();
      check("t2_tx_done_e3", tx_done, 1);
      check("t2_psel_e3", M_PSEL, 0);
      check("t2_busy_e3", busy, 0);
      step();
      check("t2_tx_done_pulse", tx_done, 0);

      // table: single bytes with varying PREADY stalls
      for (int v = 0; v < 4; v++) begin
         M_PREADY = 1'b0;
         push_byte(vecs[v].data, 1, vecs[v].exp_pwdata);
         repeat (vecs[v].stall + 2) step();
         check($sformatf("vec%0d_access", v), {M_PSEL, M_PENABLE}, 2'b11);
         check($sformatf("vec%0d_pwdata", v), M_PWDATA, vecs[v].exp_pwdata);
         M_PREADY = 1'b1;
         wait_done(4, ok);
         check($sformatf("vec%0d_done", v), ok, 1);
         check($sformatf("vec%0d_busy", v), busy, 0);
      end
      step();

      // 3: fill and stall
      M_PREADY = 1'b0;
      for (int b = 1; b <= 9; b++) push_byte(8'(b), 1, 32'(b));
      check("t3_count_full", fifo_count, 8);
      check("t3_inflight", M_PWDATA, 32'h0000_0001);
      push_byte(8'h0A, 0, 32'h0);
      check("t3_count_after_reject", fifo_count, 8);
      M_PREADY = 1'b1;
      n = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (tx_done) n++;
      end
      check("t3_tx_done_count", n, 9);
      check("t3_sb_drained", exp_q.size(), 0);
      check("t3_count_empty", fifo_count, 0);

      // 4: timeout
      M_PREADY = 1'b0;
      push_byte(8'h3C, 1, 32'h0000_003C);
      step();
      step();
      n = 0;
      ok = 1'b0;
      while (M_PENABLE && n < TIMEOUT + 10) begin
         n++;
         if (tx_done) ok = 1'b1;
         step();
      end
      check("t4_access_cycles", n, TIMEOUT);
      check("t4_psel_dropped", M_PSEL, 0);
      check("t4_timeout_err", timeout_err, 1);
      check("t4_no_tx_done", {ok, tx_done}, 2'b00);
      M_PREADY = 1'b1;
      push_byte(8'h77, 1, 32'h0000_0077);
      wait_done(6, ok);
      check("t4_next_done", ok, 1);
      check("t4_err_sticky", timeout_err, 1);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      check("t4_err_cleared", timeout_err, 0);
      // abort with clr_err held: set wins
      M_PREADY = 1'b0;
      push_byte(8'h99, 1, 32'h0000_0099);
      clr_err = 1'b1;
      step();
      step();
      n = 0;
      while (M_PENABLE && n < TIMEOUT + 10) begin
         n++;
         step();
      end
      check("t4_set_wins", timeout_err, 1);
      clr_err = 1'b0;
      step();
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      check("t4_err_cleared2", timeout_err, 0);

      // 5: deferred config, later write overwrites pending one
      push_byte(8'h11, 1, 32'h0000_0011);
      step();
      step();
      check("t5_in_access", M_PENABLE, 1);
      ctrl_we = 1'b1;
      ctrl_wdata = 8'h55;
      step();
      ctrl_wdata = 8'h0F;
      step();
      ctrl_we = 1'b0;
      check("t5_ctrl_held", uart_control, 8'h27);
      step();
      check("t5_ctrl_held2", uart_control, 8'h27);
      M_PREADY = 1'b1;
      wait_done(4, ok);
      check("t5_done", ok, 1);
      check("t5_ctrl_at_done", uart_control, 8'h27);
      step();
      check("t5_ctrl_applied", uart_control, 8'h0F);
      ctrl_we = 1'b1;
      ctrl_wdata = 8'hC3;
      step();
      ctrl_we = 1'b0;
      check("t5_ctrl_idle_write", uart_control, 8'hC3);

      // 6: enable gating, then reset mid-transfer
      enable = 1'b0;
      push_byte(8'hAA, 1, 32'h0000_00AA);
      push_byte(8'hBB, 1, 32'h0000_00BB);
      push_byte(8'hCC, 1, 32'h0000_00CC);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (M_PSEL) n++;
      end
      check("t6_no_psel", n, 0);
      check("t6_count3", fifo_count, 3);
      enable = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (tx_done) n++;
      end
      check("t6_three_done", n, 3);
      M_PREADY = 1'b0;
      push_byte(8'hDE, 1, 32'h0000_00DE);
      push_byte(8'hAD, 1, 32'h0000_00AD);
      step();
      check("t6_pre_rst_access", {M_PSEL, M_PENABLE}, 2'b11);
      #2;
      PRESETn = 1'b0;
      #1;
      check("t6_rst_psel", M_PSEL, 0);
      check("t6_rst_penable", M_PENABLE, 0);
      check("t6_rst_pwdata", M_PWDATA, 0);
      check("t6_rst_count", fifo_count, 0);
      check("t6_rst_wr_ready", wr_ready, 1);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_ctrl", uart_control, 8'h27);
      exp_q.delete();
      step();
      PRESETn = 1'b1;
      M_PREADY = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (M_PSEL) n++;
      end
      check("t6_fifo_discarded", n, 0);
      check("t6_count_after", fifo_count, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
